parity_stream_gen: RTL and testbench

PARITY_STREAM_GEN -- requirements
Module: parity_stream_gen

---
 rtl/parity_stream_gen.sv | 147 ++++++++++++++
 tb/tb_parity_stream_gen.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_gen.sv
// parity_stream_gen
//
// Streaming parity generator / checker with one output register stage.
//
// Every accepted word is copied to the output register together with its
// per-word parity. In check mode the received parity bit is also compared
// against the computed parity, and the result is flagged on out_err.
// Mismatches are counted in a saturating error counter. Separately, a
// packet-level parity is accumulated across words and published with a
// one-cycle strobe when the last word of the packet is accepted.
//
// Parameters
//   WIDTH  data word width in bits (>= 1)
//   ODD    0 = even parity, 1 = odd parity
//   CNT_W  error counter width in bits (>= 1)
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   mode               0 = generate, 1 = check (sampled per accepted word)
//   clr_cnt            clears err_cnt; wins over a same-cycle increment
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   in_data            input word
//   in_par             received parity bit, only used in check mode
//   in_last            marks the last word of a packet
//   out_valid/out_ready output handshake
//   out_data, out_last registered copies of in_data / in_last
//   out_par            per-word parity of the registered word
//   out_err            per-word parity mismatch (check mode only)
//   pkt_par            parity over the whole packet, held until next packet end
//   pkt_par_valid      one-cycle strobe aligned with the packet's last word
//   err_cnt            saturating count of mismatching words

module parity_stream_gen #(
  parameter int WIDTH = 8,
  parameter int ODD   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             clr_cnt,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_last,
  output logic             out_err,
  output logic             pkt_par,
  output logic             pkt_par_valid,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic             ODD_BIT = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_par;
  logic             r_out_last;
  logic             r_out_err;
  logic             r_pkt_par;
  logic             r_pkt_par_valid;
  logic [CNT_W-1:0] r_err_cnt;
  // Raw XOR of all words of the current packet seen so far (ODD not applied).
  logic             r_acc;

  logic w_in_xfer;
  logic w_data_xor;
  logic w_word_par;
  logic w_word_err;

  // Single register stage without skid buffer: space exists when the stage
  // is empty or is being emptied in this same cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;

  assign w_data_xor = ^in_data;
  assign w_word_par = w_data_xor ^ ODD_BIT;
  assign w_word_err = mode && (in_par != w_word_par);

  // Output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_par   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_in_xfer) begin
      // Also covers the simultaneous in/out transfer case: reload, stay valid.
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_par   <= w_word_par;
      r_out_last  <= in_last;
      r_out_err   <= w_word_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Packet parity accumulation. The strobe is asserted only in the cycle
  // after the last word is accepted, so it lines up with that word on the
  // output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc           <= 1'b0;
      r_pkt_par       <= 1'b0;
      r_pkt_par_valid <= 1'b0;
    end else begin
      r_pkt_par_valid <= w_in_xfer && in_last;
      if (w_in_xfer) begin
        if (in_last) begin
          r_pkt_par <= r_acc ^ w_data_xor ^ ODD_BIT;
          r_acc     <= 1'b0;
        end else begin
          r_acc     <= r_acc ^ w_data_xor;
        end
      end
    end
  end

  // Saturating error counter; a clear request discards any same-cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr_cnt) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_word_err && (r_err_cnt != CNT_MAX)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_data      = r_out_data;
  assign out_par       = r_out_par;
  assign out_last      = r_out_last;
  assign out_err       = r_out_err;
  assign pkt_par       = r_pkt_par;
  assign pkt_par_valid = r_pkt_par_valid;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_parity_stream_gen.sv
// Testbench for parity_stream_gen. Two instances share all inputs:
//   dut0: WIDTH=8, ODD=0 (even parity), CNT_W=2
//   dut1: WIDTH=8, ODD=1 (odd parity),  CNT_W=8
// Inputs are driven 1 ns after the rising edge; outputs are sampled 1 ns
// after the following rising edge.

module tb_parity_stream_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_par = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic [1:0] in_ready_w;
  logic [1:0] out_valid_w;
  logic [7:0] out_data_w [2];
  logic [1:0] out_par_w;
  logic [1:0] out_last_w;
  logic [1:0] out_err_w;
  logic [1:0] pkt_par_w;
  logic [1:0] pkt_pv_w;
  logic [1:0] cnt0;
  logic [7:0] cnt1;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference state (what the outputs should show now).
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_last;
  bit       m_par  [2];
  bit       m_err  [2];
  bit       m_pkt  [2];
  bit       m_pktv;
  int       m_cnt  [2];
  int       pkt_q  [$];

  always #5 clk = ~clk;

  parity_stream_gen #(.WIDTH(8), .ODD(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
    .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_par(out_par_w[0]), .out_last(out_last_w[0]), .out_err(out_err_w[0]),
    .pkt_par(pkt_par_w[0]), .pkt_par_valid(pkt_pv_w[0]), .err_cnt(cnt0)
  );

  parity_stream_gen #(.WIDTH(8), .ODD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
    .in_par(in_par), .in_last(in_last),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_par(out_par_w[1]), .out_last(out_last_w[1]), .out_err(out_err_w[1]),
    .pkt_par(pkt_par_w[1]), .pkt_par_valid(pkt_pv_w[1]), .err_cnt(cnt1)
  );

  function automatic bit ones_odd(int w);
    return ($countones(w) % 2) == 1;
  endfunction

  // Advance one clock and update the reference from the inputs that were
  // applied during that cycle.
  task automatic tick();
    bit xfer;
    int ones;
    int cmax;
    xfer = !rst && in_valid && (!m_valid || out_ready);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_data = 0; m_last = 0; m_pktv = 0;
      for (int d = 0; d < 2; d++) begin
        m_par[d] = 0; m_err[d] = 0; m_pkt[d] = 0; m_cnt[d] = 0;
      end
      pkt_q.delete();
    end else begin
      m_pktv = 0;
      if (xfer) begin
        m_valid = 1;
        m_data  = in_data;
        m_last  = in_last;
        for (int d = 0; d < 2; d++) begin
          m_par[d] = ones_odd(int'(in_data)) ^ (d == 1);
          m_err[d] = mode && (in_par != m_par[d]);
        end
        if (in_last) begin
          ones = $countones(in_data);
          foreach (pkt_q[k]) ones += $countones(pkt_q[k]);
          for (int d = 0; d < 2; d++) m_pkt[d] = ((ones % 2) == 1) ^ (d == 1);
          m_pktv = 1;
          pkt_q.delete();
        end else begin
          pkt_q.push_back(int'(in_data));
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      for (int d = 0; d < 2; d++) begin
        cmax = (d == 0) ? 3 : 255;
        if (clr_cnt) m_cnt[d] = 0;
        else if (xfer && m_err[d] && m_cnt[d] < cmax) m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; clr_cnt = 0; mode = 0; in_last = 0; out_ready = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; in_data = 8'hFF; in_last = 1;
    tick();
    tick();
    rst = 0; in_valid = 0; in_last = 0;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (out_valid_w[d] !== 1'b0 || out_par_w[d] !== 1'b0 || out_last_w[d] !== 1'b0 ||
          out_err_w[d] !== 1'b0 || pkt_par_w[d] !== 1'b0 || pkt_pv_w[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_flags[%0d]: got v=%b p=%b l=%b e=%b pp=%b ppv=%b expected all 0",
                 d, out_valid_w[d], out_par_w[d], out_last_w[d], out_err_w[d], pkt_par_w[d], pkt_pv_w[d]);
      end
      vectors++;
      if (out_data_w[d] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_data[%0d]: got %h expected 00", d, out_data_w[d]);
      end
      vectors++;
      if (in_ready_w[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready_w[d]);
      end
    end
    vectors++;
    if (cnt0 !== 2'd0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_err_cnt: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
  endtask

  task automatic test_even_gen();
    bit [7:0] words [2] = '{8'hA5, 8'h07};
    bit       exp_p [2] = '{1'b0, 1'b1};
    do_reset();
    mode = 0; out_ready = 1; in_par = 1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = words[i]; in_last = 0;
      tick();
      vectors++;
      if (out_valid_w[0] !== 1'b1 || out_data_w[0] !== words[i]) begin
        miscompares++;
        $display("FAIL even_gen_data %h: got v=%b d=%h expected v=1 d=%h", words[i], out_valid_w[0], out_data_w[0], words[i]);
      end
      vectors++;
      if (out_par_w[0] !== exp_p[i] || out_err_w[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL even_gen_par %h: got par=%b err=%b expected par=%b err=0", words[i], out_par_w[0], out_err_w[0], exp_p[i]);
      end
    end
    in_valid = 0;
    tick();
    vectors++;
    if (out_valid_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL even_gen_drain: got out_valid=%b expected 0", out_valid_w[0]);
    end
  endtask

  task automatic test_odd_gen();
    bit [7:0] words [3] = '{8'h00, 8'hFF, 8'h01};
    bit       exp_p [3] = '{1'b1, 1'b1, 1'b0};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = words[i]; in_last = 0;
      tick();
      vectors++;
      if (out_par_w[1] !== exp_p[i]) begin
        miscompares++;
        $display("FAIL odd_gen_par %h: got %b expected %b", words[i], out_par_w[1], exp_p[i]);
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; in_data = 8'h3C; in_last = 0; out_ready = 1;
    tick();
    out_ready = 0; in_data = 8'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready_w[0] !== 1'b0 || out_data_w[0] !== 8'h3C || out_valid_w[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=3c",
                 i, in_ready_w[0], out_valid_w[0], out_data_w[0]);
      end
      tick();
    end
    out_ready = 1;
    #1;
    vectors++;
    if (in_ready_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready_w[0]);
    end
    tick();
    vectors++;
    if (out_data_w[0] !== 8'h0F || out_valid_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_reload: got v=%b d=%h expected v=1 d=0f", out_valid_w[0], out_data_w[0]);
    end
    in_valid = 0;
    tick();
    vectors++;
    if (out_valid_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid_w[0]);
    end
  endtask

  task automatic test_packet();
    bit [7:0] words [3] = '{8'h01, 8'h03, 8'h07};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = words[i]; in_last = (i == 2);
      tick();
      if (i < 2) begin
        vectors++;
        if (pkt_pv_w[0] !== 1'b0) begin
          miscompares++;
          $display("FAIL pkt_strobe_early word %0d: got %b expected 0", i, pkt_pv_w[0]);
        end
      end
    end
    vectors++;
    if (pkt_pv_w[0] !== 1'b1 || pkt_par_w[0] !== 1'b0 || out_last_w[0] !== 1'b1 || out_valid_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_end_even: got ppv=%b pp=%b last=%b v=%b expected 1 0 1 1",
               pkt_pv_w[0], pkt_par_w[0], out_last_w[0], out_valid_w[0]);
    end
    vectors++;
    if (pkt_par_w[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_end_odd: got %b expected 1", pkt_par_w[1]);
    end
    in_valid = 0; in_last = 0;
    tick();
    vectors++;
    if (pkt_pv_w[0] !== 1'b0 || pkt_par_w[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL pkt_strobe_one_cycle: got ppv=%b pp=%b expected 0 0", pkt_pv_w[0], pkt_par_w[0]);
    end
    in_valid = 1; in_data = 8'h01; in_last = 1;
    tick();
    vectors++;
    if (pkt_pv_w[0] !== 1'b1 || pkt_par_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_single_word: got ppv=%b pp=%b expected 1 1", pkt_pv_w[0], pkt_par_w[0]);
    end
    in_valid = 0; in_last = 0;
    tick();
  endtask

  task automatic test_check_mode();
    do_reset();
    mode = 1; out_ready = 1; in_valid = 1; in_data = 8'h01; in_par = 0; in_last = 0;
    tick();
    vectors++;
    if (out_err_w[0] !== 1'b1 || cnt0 !== 2'd1) begin
      miscompares++;
      $display("FAIL chk_first_err: got err=%b cnt=%0d expected 1 1", out_err_w[0], cnt0);
    end
    vectors++;
    if (out_err_w[1] !== 1'b0 || cnt1 !== 8'd0) begin
      miscompares++;
      $display("FAIL chk_odd_match: got err=%b cnt=%0d expected 0 0", out_err_w[1], cnt1);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (cnt0 !== 2'd3) begin
      miscompares++;
      $display("FAIL chk_saturate: got %0d expected 3", cnt0);
    end
    in_par = 1;
    tick();
    vectors++;
    if (out_err_w[0] !== 1'b0 || cnt0 !== 2'd3 || out_err_w[1] !== 1'b1 || cnt1 !== 8'd1) begin
      miscompares++;
      $display("FAIL chk_par1: got e0=%b c0=%0d e1=%b c1=%0d expected 0 3 1 1",
               out_err_w[0], cnt0, out_err_w[1], cnt1);
    end
    in_par = 0; clr_cnt = 1;
    tick();
    vectors++;
    if (cnt0 !== 2'd0 || out_err_w[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL chk_clr_wins: got cnt=%0d err=%b expected 0 1", cnt0, out_err_w[0]);
    end
    clr_cnt = 0; mode = 0;
    tick();
    vectors++;
    if (out_err_w[0] !== 1'b0 || cnt0 !== 2'd0) begin
      miscompares++;
      $display("FAIL chk_gen_ignores_par: got err=%b cnt=%0d expected 0 0", out_err_w[0], cnt0);
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1; in_valid = 1; in_data = 8'h01; in_last = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    vectors++;
    if (out_valid_w !== 2'b00 || out_data_w[0] !== 8'h00 || out_par_w !== 2'b00 ||
        pkt_par_w !== 2'b00 || pkt_pv_w !== 2'b00) begin
      miscompares++;
      $display("FAIL midpkt_reset_outputs: got v=%b d=%h p=%b pp=%b ppv=%b expected zeros",
               out_valid_w, out_data_w[0], out_par_w, pkt_par_w, pkt_pv_w);
    end
    in_last = 1;
    tick();
    vectors++;
    if (pkt_par_w[0] !== 1'b1 || pkt_pv_w[0] !== 1'b1 || pkt_par_w[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL midpkt_new_packet: got pp0=%b ppv=%b pp1=%b expected 1 1 0",
               pkt_par_w[0], pkt_pv_w[0], pkt_par_w[1]);
    end
    in_valid = 0; in_last = 0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      mode      = $urandom_range(0, 1);
      clr_cnt   = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_par    = $urandom_range(0, 1);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (in_ready_w[d] !== (!m_valid || out_ready)) begin
          miscompares++;
          $display("FAIL rnd_in_ready[%0d] cyc %0d: got %b expected %b", d, i, in_ready_w[d], !m_valid || out_ready);
        end
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (out_valid_w[d] !== m_valid || out_data_w[d] !== m_data || out_last_w[d] !== m_last) begin
          miscompares++;
          $display("FAIL rnd_out_word[%0d] cyc %0d: got v=%b d=%h l=%b expected v=%b d=%h l=%b",
                   d, i, out_valid_w[d], out_data_w[d], out_last_w[d], m_valid, m_data, m_last);
        end
        vectors++;
        if (out_par_w[d] !== m_par[d] || out_err_w[d] !== m_err[d]) begin
          miscompares++;
          $display("FAIL rnd_par_err[%0d] cyc %0d: got p=%b e=%b expected p=%b e=%b",
                   d, i, out_par_w[d], out_err_w[d], m_par[d], m_err[d]);
        end
        vectors++;
        if (pkt_par_w[d] !== m_pkt[d] || pkt_pv_w[d] !== m_pktv) begin
          miscompares++;
          $display("FAIL rnd_pkt[%0d] cyc %0d: got pp=%b ppv=%b expected pp=%b ppv=%b",
                   d, i, pkt_par_w[d], pkt_pv_w[d], m_pkt[d], m_pktv);
        end
      end
      vectors++;
      if (cnt0 !== m_cnt[0][1:0] || cnt1 !== m_cnt[1][7:0]) begin
        miscompares++;
        $display("FAIL rnd_err_cnt cyc %0d: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, m_cnt[0], m_cnt[1]);
      end
    end
    rst = 0; clr_cnt = 0; in_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_even_gen();
    test_odd_gen();
    test_backpressure();
    test_packet();
    test_check_mode();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
